// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for a 4-register, shared-bus datapath feeding a multi-stage ALU.
// Latches one instruction per Run, sequences bus/ALU strobes through T1..T4, and counts retired instructions.
module alu_sequencer #(
   parameter int N  = 10,
   parameter int CW = 16
) (
   input  logic          CLKb,
   input  logic          RST,
   input  logic          Run,
   input  logic [N-1:0]  DIN,
   output logic          IRout,
   output logic          ExtOut,
   output logic [3:0]    Rout,
   output logic [3:0]    Rin,
   output logic          Ain,
   output logic          Gin,
   output logic          Gout,
   output logic [3:0]    FN,
   output logic          Done,
   output logic          Busy,
   output logic [CW-1:0] Count
);

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      T3,
      T4
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  ir;

   logic [1:0]    ir_class;
   logic [1:0]    rx;
   logic [1:0]    ry;
   logic [3:0]    op;
   logic          is_alu;
   logic          is_reg_alu;
   logic          is_load;
   logic          is_mov;

   assign ir_class   = ir[9:8];
   assign rx         = ir[7:6];
   assign ry         = ir[5:4];
   assign op         = ir[3:0];
   assign is_reg_alu = (ir_class == 2'b00);
   assign is_alu     = is_reg_alu || ir_class[1];
   assign is_load    = (ir_class == 2'b01) && (op == 4'b0000);
   assign is_mov     = (ir_class == 2'b01) && (op == 4'b0001);

   function automatic logic [3:0] reg_sel(input logic [1:0] r);
      reg_sel = 4'b0001 << r;
   endfunction

   always_ff @(posedge CLKb) begin
      if (RST) begin
         state <= IDLE;
         ir    <= '0;
         Count <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && Run) begin
            ir <= DIN;
         end
         if (Done) begin
            Count <= Count + CW'(1);
         end
      end
   end

   // Moore decode: every strobe depends only on the current state and the latched IR.
   always_comb begin
      state_next = state;
      IRout      = 1'b0;
      ExtOut     = 1'b0;
      Rout       = 4'b0000;
      Rin        = 4'b0000;
      Ain        = 1'b0;
      Gin        = 1'b0;
      Gout       = 1'b0;
      FN         = 4'b0000;
      Done       = 1'b0;
      Busy       = (state != IDLE);

      case (state)
         IDLE: begin
            if (Run) begin
               state_next = T1;
            end
         end
         T1: begin
            if (is_alu) begin
               Rout       = reg_sel(rx);
               Ain        = 1'b1;
               state_next = T2;
            end else if (is_load) begin
               ExtOut     = 1'b1;
               Rin        = reg_sel(rx);
               Done       = 1'b1;
               state_next = IDLE;
            end else if (is_mov) begin
               Rout       = reg_sel(ry);
               Rin        = reg_sel(rx);
               Done       = 1'b1;
               state_next = IDLE;
            end else begin
               Done       = 1'b1;
               state_next = IDLE;
            end
         end
         T2: begin
            // Immediate forms put IR on the bus instead of a second register.
            if (is_reg_alu) begin
               Rout = reg_sel(ry);
               Gin  = 1'b1;
            end else begin
               IRout = 1'b1;
            end
            state_next = T3;
         end
         T3: begin
            IRout      = 1'b1;
            Gout       = 1'b1;
            state_next = T4;
         end
         T4: begin
            Gout       = 1'b1;
            Rin        = reg_sel(rx);
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (state != IDLE && is_reg_alu) begin
         FN = op;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: reset, ALU/immediate/LOAD/MOV/NOP
// sequencing, Run held across an instruction, and reset aborting an instruction mid-flight.
module tb_alu_sequencer;

   logic        CLKb;
   logic        RST;
   logic        Run;
   logic [9:0]  DIN;
   logic        IRout;
   logic        ExtOut;
   logic [3:0]  Rout;
   logic [3:0]  Rin;
   logic        Ain;
   logic        Gin;
   logic        Gout;
   logic [3:0]  FN;
   logic        Done;
   logic        Busy;
   logic [15:0] Count;

   int checkCount;
   int errorCount;

   alu_sequencer #(.N(10), .CW(16)) dut (
      .CLKb   (CLKb),
      .RST    (RST),
      .Run    (Run),
      .DIN    (DIN),
      .IRout  (IRout),
      .ExtOut (ExtOut),
      .Rout   (Rout),
      .Rin    (Rin),
      .Ain    (Ain),
      .Gin    (Gin),
      .Gout   (Gout),
      .FN     (FN),
      .Done   (Done),
      .Busy   (Busy),
      .Count  (Count)
   );

   initial begin
      CLKb = 1'b0;
      forever #5 CLKb = ~CLKb;
   end

   task automatic applyStimulus(input logic rst, input logic run, input logic [9:0] din);
      RST = rst;
      Run = run;
      DIN = din;
   endtask

   // Advance one rising edge and settle before sampling outputs.
   task automatic stepClk();
      @(posedge CLKb);
      #1;
   endtask

   task automatic checkOutput(
      input string       tag,
      input logic [3:0]  eRout,
      input logic [3:0]  eRin,
      input logic        eIRout,
      input logic        eExt,
      input logic        eAin,
      input logic        eGin,
      input logic        eGout,
      input logic [3:0]  eFn,
      input logic        eDone,
      input logic        eBusy,
      input logic [15:0] eCount
   );
      logic [34:0] observed;
      logic [34:0] expected;
      observed = {Rout, Rin, IRout, ExtOut, Ain, Gin, Gout, FN, Done, Busy, Count};
      expected = {eRout, eRin, eIRout, eExt, eAin, eGin, eGout, eFn, eDone, eBusy, eCount};
      checkCount++;
      assert (observed === expected)
      else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;

      // Reset held two cycles with Run high and a valid instruction presented.
      applyStimulus(1'b1, 1'b1, 10'b0001100010);
      stepClk();
      stepClk();
      checkOutput("reset", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd0);
      applyStimulus(1'b0, 1'b0, 10'b0001100010);
      stepClk();
      checkOutput("idle_after_reset", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd0);

      // ADD R1,R2
      applyStimulus(1'b0, 1'b1, 10'b0001100010);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("add_t1", 4'b0010, 4'b0000, 0, 0, 1, 0, 0, 4'b0010, 0, 1, 16'd0);
      stepClk();
      checkOutput("add_t2", 4'b0100, 4'b0000, 0, 0, 0, 1, 0, 4'b0010, 0, 1, 16'd0);
      stepClk();
      checkOutput("add_t3", 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 4'b0010, 0, 1, 16'd0);
      stepClk();
      checkOutput("add_t4", 4'b0000, 4'b0010, 0, 0, 0, 0, 1, 4'b0010, 1, 1, 16'd0);
      stepClk();
      checkOutput("add_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd1);

      // ADDI R3,#5
      applyStimulus(1'b0, 1'b1, 10'b1011000101);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("addi_t1", 4'b1000, 4'b0000, 0, 0, 1, 0, 0, 4'h0, 0, 1, 16'd1);
      stepClk();
      checkOutput("addi_t2", 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'h0, 0, 1, 16'd1);
      stepClk();
      checkOutput("addi_t3", 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 4'h0, 0, 1, 16'd1);
      stepClk();
      checkOutput("addi_t4", 4'b0000, 4'b1000, 0, 0, 0, 0, 1, 4'h0, 1, 1, 16'd1);
      stepClk();
      checkOutput("addi_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd2);

      // LOAD R2
      applyStimulus(1'b0, 1'b1, 10'b0110000000);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("load_t1", 4'b0000, 4'b0100, 0, 1, 0, 0, 0, 4'h0, 1, 1, 16'd2);
      stepClk();
      checkOutput("load_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd3);

      // MOV R0,R3
      applyStimulus(1'b0, 1'b1, 10'b0100110001);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("mov_t1", 4'b1000, 4'b0001, 0, 0, 0, 0, 0, 4'h0, 1, 1, 16'd3);
      stepClk();
      checkOutput("mov_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd4);

      // NOP (class 01, op 0111)
      applyStimulus(1'b0, 1'b1, 10'b0101000111);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("nop_t1", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 1, 1, 16'd4);
      stepClk();
      checkOutput("nop_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd5);

      // Run held high: reg ALU R2,R0 fn 0011, DIN switched to LOAD R1 during T2
      applyStimulus(1'b0, 1'b1, 10'b0010000011);
      stepClk();
      checkOutput("hold_t1", 4'b0100, 4'b0000, 0, 0, 1, 0, 0, 4'b0011, 0, 1, 16'd5);
      stepClk();
      applyStimulus(1'b0, 1'b1, 10'b0101000000);
      checkOutput("hold_t2", 4'b0001, 4'b0000, 0, 0, 0, 1, 0, 4'b0011, 0, 1, 16'd5);
      stepClk();
      checkOutput("hold_t3", 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 4'b0011, 0, 1, 16'd5);
      stepClk();
      checkOutput("hold_t4", 4'b0000, 4'b0100, 0, 0, 0, 0, 1, 4'b0011, 1, 1, 16'd5);
      stepClk();
      checkOutput("hold_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd6);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("hold_next_load", 4'b0000, 4'b0010, 0, 1, 0, 0, 0, 4'h0, 1, 1, 16'd6);
      stepClk();
      checkOutput("hold_next_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd7);

      // SUBI R1,#3 aborted by reset in T3
      applyStimulus(1'b0, 1'b1, 10'b1101000011);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("subi_t1", 4'b0010, 4'b0000, 0, 0, 1, 0, 0, 4'h0, 0, 1, 16'd7);
      stepClk();
      checkOutput("subi_t2", 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'h0, 0, 1, 16'd7);
      stepClk();
      checkOutput("subi_t3", 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 4'h0, 0, 1, 16'd7);
      applyStimulus(1'b1, 1'b0, 10'b0000000000);
      stepClk();
      checkOutput("abort_reset", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd0);
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      stepClk();
      checkOutput("abort_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd0);

      // Fresh ADD R1,R1 fn 0001 after the abort
      applyStimulus(1'b0, 1'b1, 10'b0001010001);
      stepClk();
      applyStimulus(1'b0, 1'b0, 10'b0000000000);
      checkOutput("fresh_t1", 4'b0010, 4'b0000, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 16'd0);
      stepClk();
      checkOutput("fresh_t2", 4'b0010, 4'b0000, 0, 0, 0, 1, 0, 4'b0001, 0, 1, 16'd0);
      stepClk();
      checkOutput("fresh_t3", 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 4'b0001, 0, 1, 16'd0);
      stepClk();
      checkOutput("fresh_t4", 4'b0000, 4'b0010, 0, 0, 0, 0, 1, 4'b0001, 1, 1, 16'd0);
      stepClk();
      checkOutput("fresh_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM that sits directly upstream of the multi-stage ALU.
- Latches a 10-bit instruction and steps the register file, bus drivers and ALU strobes (Ain, Gin, Gout, FN) through each instruction.
- Pulses Done when the write-back completes.
- Targets a 4-register datapath (R0..R3) with a shared N-bit bus; the ALU RES output feeds the register-file write port directly, not the bus.

Parameters:
N, 10, instruction and bus width; the encoding below requires N = 10.
CW, 16, width of the retired-instruction counter.

Ports:
CLKb  in  1  clock; all state updates on its rising edge
RST  in  1  synchronous active-high reset
Run  in  1  start request, sampled only in IDLE
DIN  in  N  instruction word, latched into IR when Run is accepted
IRout  out  1  drive IR onto bus
ExtOut  out  1  drive external data onto bus
Rout  out  4  one-hot register-to-bus enable
Rin  out  4  one-hot register write enable
Ain  out  1  ALU A-capture strobe
Gin  out  1  ALU B-capture strobe
Gout  out  1  ALU result latch/enable
FN  out  4  ALU function code, equals IR[3:0]
Done  out  1  one-cycle completion pulse
Busy  out  1  high whenever state is not IDLE
Count  out  CW  retired-instruction count

Behaviour:
- Interface: one clock, CLKb. Reset RST is synchronous and active-high.
- Instruction encoding:
  - IR[9:8] = class; IR[7:6] = Rx (destination and first operand).
  - Class 00 (reg ALU): IR[5:4] = Ry, IR[3:0] = FN.
  - Class 10 (ADDI) and class 11 (SUBI): IR[5:0] = immediate; ALU takes the immediate from the bus.
  - Class 01: IR[3:0] = 0000 is LOAD (Rx <- external), 0001 is MOV (Rx <- Ry); any other value is NOP.
- Reset:
  - State goes to IDLE; IR and Count are cleared.
  - All outputs are 0, including FN = 0000.
  - Reset has priority over every other input, including in mid-instruction. An aborted instruction never pulses Done and is not counted.
- States are IDLE, T1, T2, T3, T4. Outputs are Moore-decoded from state and IR; anything not listed below is 0.
- IDLE:
  - Busy = 0.
  - If Run = 1 at an edge: IR <= DIN and go to T1. Otherwise stay in IDLE.
- T1:
  - Class 00/10/11: Rout[Rx] = 1, Ain = 1; go to T2.
  - LOAD: ExtOut = 1, Rin[Rx] = 1, Done = 1; go to IDLE.
  - MOV: Rout[Ry] = 1, Rin[Rx] = 1, Done = 1; go to IDLE.
  - NOP: Done = 1 only; go to IDLE.
- T2:
  - Class 00: Rout[Ry] = 1, Gin = 1.
  - Class 10/11: IRout = 1, Gin = 0.
  - Go to T3.
- T3: IRout = 1, Gout = 1. The ALU sees the class bits and immediate on the bus and latches RES on the CLKb falling edge. Go to T4.
- T4: Gout = 1, Rin[Rx] = 1, Done = 1. Go to IDLE.
- FN is driven as IR[3:0] in T1..T4 for class 00 and is 0 otherwise. Undefined FN codes are still sequenced normally; the ALU produces 0.
- Latency from the Run-accept edge to the Done cycle: ALU ops take 4 cycles; LOAD, MOV and NOP take 1 cycle.
- Count increments by 1 (mod 2^CW) in every cycle where Done = 1.
- Run and DIN are ignored while Busy = 1. If Run is still high in the cycle after Done, the state is IDLE and the next instruction is accepted at that edge (back-to-back, no dead cycle beyond IDLE).
- Invariants, every cycle:
  - At most one of {any Rout bit, IRout, ExtOut} is asserted.
  - Rout and Rin are each one-hot or zero.
  - Done implies exactly one Rin bit is set, except for NOP.
- Rx = Ry is legal, e.g. ADD R1,R1 or MOV R2,R2.

Test Plan:
- Reset: RST = 1 for 2 cycles with Run = 1 -> all outputs 0, Busy = 0, Count = 0; IR is not loaded while RST = 1.
- ADD R1,R2: DIN = 10'b0001100010, Run pulse ->
  - T1: Rout = 0010, Ain = 1.
  - T2: Rout = 0100, Gin = 1.
  - T3: IRout = 1, Gout = 1, FN = 0010.
  - T4: Rin = 0010, Gout = 1, Done = 1; Count = 1.
- ADDI R3,#5: DIN = 10'b1011000101 ->
  - T1: Rout = 1000, Ain = 1.
  - T2: IRout = 1, Gin = 0.
  - T3: IRout = 1, Gout = 1.
  - T4: Rin = 1000, Done = 1.
  - FN = 0000 throughout.
- LOAD R2: DIN = 10'b0110000000 -> one cycle with ExtOut = 1, Rin = 0100, Done = 1, then IDLE. MOV R0,R3 (10'b0100110001) -> Rout = 1000, Rin = 0001, Done = 1.
- Run held high with DIN changed during T2 -> IR is unchanged and sequencing completes. At the edge after the T4 Done cycle the new DIN is latched (T1 follows the IDLE cycle). Count reaches 2.
- RST asserted during T3 of a SUB -> next cycle is IDLE with all outputs 0, no Done pulse, Count = 0. A fresh Run after reset executes normally.
